branch_resolve_queue: RTL
=========================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter GHR_WIDTH, default 4: width of the stored global-history snapshot and of upd_ghr.
REQ-002 Parameter DEPTH, default 4, power of two, at least 2: number of in-flight branch entries.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alloc_valid  input  1  a branch prediction was issued this cycle.
REQ-006 alloc_pred_taken  input  1  the predicted direction of that branch.
REQ-007 alloc_ghr  input  GHR_WIDTH  the predictor history value used for that prediction.
REQ-008 alloc_ready  output  1  high when the queue is not full.
REQ-009 resolve_valid  input  1  the oldest in-flight branch resolved this cycle; branches resolve in order.
REQ-010 resolve_taken  input  1  the actual direction of the resolving branch.
REQ-011 upd_enable  output  1  registered one-cycle pulse that drives the predictor's update enable.
REQ-012 upd_taken  output  1  actual direction paired with upd_enable.
REQ-013 upd_ghr  output  GHR_WIDTH  history snapshot of the resolved entry, paired with upd_enable.
REQ-014 mispredict  output  1  registered one-cycle pulse: the resolved direction differed from the prediction.
REQ-015 occupancy  output  log2(DEPTH)+1  current number of valid entries.
REQ-016 resolve_error  output  1  sticky flag: a resolve arrived while the queue was empty.
REQ-017 stat_resolved, stat_mispredicted  output  16 each  statistics counters (see REQ-034).

Function
REQ-018 The queue is a circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 alloc_ready = (occupancy != DEPTH); it is computed from the current state only and does not look ahead at a same-cycle resolve.
REQ-020 Allocation is accepted when alloc_valid && alloc_ready: write {alloc_pred_taken, alloc_ghr} at the tail, then increment the tail.
REQ-021 alloc_valid while full is dropped silently, with no state change.
REQ-022 Resolve with the queue non-empty pops the head entry.
- Next cycle: upd_enable=1, upd_taken=resolve_taken, upd_ghr=entry ghr.
- Same next cycle: mispredict = (entry pred != resolve_taken).
REQ-023 Resolve with the queue empty: no pop, upd_enable stays 0, resolve_error is set to 1 and held until reset.
REQ-024 Correct resolve together with an accepted alloc in the same cycle: both take effect and occupancy is unchanged.
REQ-025 Mispredicting resolve: every entry younger than the head is flushed and any same-cycle alloc is discarded.
- occupancy=0 on the next cycle.
- head and tail are set equal; no specific pointer value is required.
REQ-026 Resolve while full and correct: pop only; the same-cycle alloc is not accepted, per REQ-019.
REQ-027 Latency from resolve_valid to upd_enable and mispredict is exactly 1 cycle; both outputs are 0 in every cycle not produced by a resolve.
REQ-028 Entry storage needs no reset; validity is defined solely by the pointers and the occupancy count.

Reset
REQ-029 Asserting rst immediately sets the following, independent of clk:
- head=0, tail=0, occupancy=0;
- upd_enable=0, upd_taken=0, upd_ghr=0;
- mispredict=0, resolve_error=0;
- both stat counters=0;
- alloc_ready=1.
REQ-030 Reset asserted mid-operation discards all in-flight entries and any pending output pulses.
REQ-031 The first alloc or resolve is honoured on the first rising edge after rst deasserts.

Configuration
REQ-032 The macro BRQ_STATS_EN controls the statistics counters.
REQ-033 Without BRQ_STATS_EN, stat_resolved and stat_mispredicted are tied to constant 0 and no counter flops are built.
REQ-034 With BRQ_STATS_EN:
- stat_resolved increments once per popped resolve;
- stat_mispredicted increments once per mispredicting resolve;
- both counters saturate at 16'hFFFF and do not wrap;
- both update in the same cycle as upd_enable.

Verification
REQ-035 Reset, then alloc pred=1 ghr=4'h5, then resolve taken=1: next cycle upd_enable=1, upd_taken=1, upd_ghr=4'h5, mispredict=0, occupancy=0.
REQ-036 Fill 4 entries: alloc_ready=0 and occupancy=4; a fifth alloc is dropped; four correct resolves return ghr values in allocation order; a further alloc and resolve prove that the pointers wrapped correctly.
REQ-037 Queue holds 3 entries and the head pred=1; resolve taken=0 with a simultaneous alloc: next cycle mispredict=1, occupancy=0, and the alloc is lost.
REQ-038 Empty queue; resolve_valid=1: upd_enable stays 0 and resolve_error=1, and it remains 1 after 10 idle cycles.
REQ-039 Queue holds 2 entries; assert rst between clock edges: all outputs clear asynchronously before the next edge, and alloc_ready=1.
REQ-040 With BRQ_STATS_EN: 3 correct and 2 mispredicting resolves give stat_resolved=5 and stat_mispredicted=2; without the macro both read 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// Purpose:
//    Holds every in-flight conditional-branch prediction as a pair
//    {predicted direction, global-history snapshot}, in issue order. When the
//    oldest branch resolves, its entry is popped. The real direction and the
//    saved history are then sent to the predictor as a one-cycle update pulse.
//    A wrong prediction flushes every younger entry, because those entries
//    were fetched down the wrong path.
//
// Parameters:
//    GHR_WIDTH   width of the stored history snapshot (default 4)
//    DEPTH       number of entries; a power of two, at least 2 (default 4)
//
// Ports:
//    clk                  sole clock, rising edge
//    rst                  asynchronous active-high reset
//    alloc_valid          a prediction was issued this cycle
//    alloc_pred_taken     predicted direction of that branch
//    alloc_ghr            history value used for that prediction
//    alloc_ready          queue is not full (current state only)
//    resolve_valid        oldest branch resolved this cycle
//    resolve_taken        actual direction of the resolving branch
//    upd_enable           registered one-cycle predictor-update pulse
//    upd_taken            actual direction paired with upd_enable
//    upd_ghr              history snapshot paired with upd_enable
//    mispredict           registered one-cycle pulse on a wrong prediction
//    occupancy            number of valid entries
//    resolve_error        sticky: a resolve arrived while the queue was empty
//    stat_resolved        count of popped resolves (saturating)
//    stat_mispredicted    count of mispredicting resolves (saturating)
//
// Configuration macro:
//    BRQ_STATS_EN   when defined, builds the two saturating statistics
//                   counters. When undefined, both stat outputs read 0 and
//                   no counter flops exist.
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int GHR_WIDTH = 4,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_valid,
   input  logic                     alloc_pred_taken,
   input  logic [GHR_WIDTH-1:0]     alloc_ghr,
   output logic                     alloc_ready,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   output logic                     upd_enable,
   output logic                     upd_taken,
   output logic [GHR_WIDTH-1:0]     upd_ghr,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     resolve_error,
   output logic [15:0]              stat_resolved,
   output logic [15:0]              stat_mispredicted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

   // Entry storage. It is never reset, because the pointers and the count
   // alone decide which entries are valid.
   logic                 predMem [DEPTH];
   logic [GHR_WIDTH-1:0] ghrMem  [DEPTH];

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [OCC_W-1:0]     occ_q, occ_d;

   logic                 updEnable_q;
   logic                 updTaken_q;
   logic [GHR_WIDTH-1:0] updGhr_q;
   logic                 mispredict_q;
   logic                 resolveError_q;

   logic                 isEmpty;
   logic                 doPop;
   logic                 doMiss;
   logic                 doAlloc;

   assign isEmpty     = (occ_q == '0);
   assign alloc_ready = (occ_q != FULL_COUNT);

   // Decode this cycle's events. A mispredict overrides any same-cycle
   // allocation, because that branch came from the wrong path. alloc_ready
   // does not look ahead at a pop, so a full queue refuses an alloc even
   // when a correct resolve frees a slot in the same cycle.
   always_comb begin
      doPop   = resolve_valid && !isEmpty;
      doMiss  = doPop && (predMem[head_q] != resolve_taken);
      doAlloc = alloc_valid && alloc_ready && !doMiss;
   end

   // Next-state logic for the pointers and the count. On a flush, both
   // pointers move to the slot after the popped head. Any value would do,
   // provided head and tail end up equal.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (doMiss) begin
         head_d = head_q + PTR_W'(1);
         tail_d = head_q + PTR_W'(1);
         occ_d  = '0;
      end else begin
         if (doPop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (doAlloc) begin
            tail_d = tail_q + PTR_W'(1);
         end
         occ_d = occ_q + OCC_W'(doAlloc) - OCC_W'(doPop);
      end
   end

   // Pointer, count and output-pulse registers. Reset clears them all
   // asynchronously, which also drops any pulse that was about to appear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         occ_q          <= '0;
         updEnable_q    <= 1'b0;
         updTaken_q     <= 1'b0;
         updGhr_q       <= '0;
         mispredict_q   <= 1'b0;
         resolveError_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         occ_q        <= occ_d;
         updEnable_q  <= doPop;
         mispredict_q <= doMiss;
         if (doPop) begin
            updTaken_q <= resolve_taken;
            updGhr_q   <= ghrMem[head_q];
         end
         if (resolve_valid && isEmpty) begin
            resolveError_q <= 1'b1;
         end
      end
   end

   // Write an accepted allocation into the tail slot.
   always_ff @(posedge clk) begin
      if (doAlloc) begin
         predMem[tail_q] <= alloc_pred_taken;
         ghrMem[tail_q]  <= alloc_ghr;
      end
   end

`ifdef BRQ_STATS_EN
   logic [15:0] statResolved_q;
   logic [15:0] statMispredicted_q;

   // Saturating statistics counters. They advance on the same edge that
   // raises upd_enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         statResolved_q     <= '0;
         statMispredicted_q <= '0;
      end else begin
         if (doPop && (statResolved_q != 16'hFFFF)) begin
            statResolved_q <= statResolved_q + 16'd1;
         end
         if (doMiss && (statMispredicted_q != 16'hFFFF)) begin
            statMispredicted_q <= statMispredicted_q + 16'd1;
         end
      end
   end

   assign stat_resolved     = statResolved_q;
   assign stat_mispredicted = statMispredicted_q;
`else
   assign stat_resolved     = 16'h0000;
   assign stat_mispredicted = 16'h0000;
`endif

   assign upd_enable    = updEnable_q;
   assign upd_taken     = updTaken_q;
   assign upd_ghr       = updGhr_q;
   assign mispredict    = mispredict_q;
   assign occupancy     = occ_q;
   assign resolve_error = resolveError_q;

endmodule
